// File: rtl/matcher_if.sv
// matcher_if: groups the lookup request/result, key-configuration and
// table-write signals of the match stage.
//   slave  modport - used by the matcher itself
//   master modport - used by whoever drives lookups and table updates
// Signal summary:
//   start_i / pkt_hdr_i / parsed_hdrs_i        : lookup request + header snapshot
//   ready_o / is_match_o / args_o              : lookup result (ready_o pulses)
//   pkt_hdr_o / parsed_hdrs_o                  : header registered at start
//   mod_start_i / mod_key_{hdr,off,len}_i      : key-extraction configuration
//   tbl_wr_{en,addr,valid,key,val}_i           : exact-match table write port
interface matcher_if #(
    parameter int HDR_MAX_LEN = 128,
    parameter int NUM_HEADERS = 16,
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_LEN     = 16,
    parameter int MAX_VAL_LEN = 16
);
    localparam int AW = $clog2(NUM_ENTRIES);

    logic                              start_i;
    logic [HDR_MAX_LEN-1:0][7:0]       pkt_hdr_i;
    logic [NUM_HEADERS-1:0][31:0]      parsed_hdrs_i;
    logic                              ready_o;
    logic                              is_match_o;
    logic [MAX_VAL_LEN-1:0][7:0]       args_o;
    logic [HDR_MAX_LEN-1:0][7:0]       pkt_hdr_o;
    logic [NUM_HEADERS-1:0][31:0]      parsed_hdrs_o;
    logic                              mod_start_i;
    logic [3:0]                        mod_key_hdr_i;
    logic [5:0]                        mod_key_off_i;
    logic [4:0]                        mod_key_len_i;
    logic                              tbl_wr_en_i;
    logic [AW-1:0]                     tbl_wr_addr_i;
    logic                              tbl_wr_valid_i;
    logic [KEY_LEN-1:0][7:0]           tbl_wr_key_i;
    logic [MAX_VAL_LEN-1:0][7:0]       tbl_wr_val_i;

    modport slave (
        input  start_i, pkt_hdr_i, parsed_hdrs_i,
        input  mod_start_i, mod_key_hdr_i, mod_key_off_i, mod_key_len_i,
        input  tbl_wr_en_i, tbl_wr_addr_i, tbl_wr_valid_i, tbl_wr_key_i, tbl_wr_val_i,
        output ready_o, is_match_o, args_o, pkt_hdr_o, parsed_hdrs_o
    );

    modport master (
        output start_i, pkt_hdr_i, parsed_hdrs_i,
        output mod_start_i, mod_key_hdr_i, mod_key_off_i, mod_key_len_i,
        output tbl_wr_en_i, tbl_wr_addr_i, tbl_wr_valid_i, tbl_wr_key_i, tbl_wr_val_i,
        input  ready_o, is_match_o, args_o, pkt_hdr_o, parsed_hdrs_o
    );
endinterface

// File: rtl/matcher.sv
// matcher: exact-match lookup stage. Extracts a key from the registered
// packet header using the configured (header, offset, length), then scans
// the table one entry per cycle; the lowest-index valid matching entry wins.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - matcher_if.slave (request/result, key config, table writes)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting; accepts config load or a lookup start
// S_EXTRACT| builds the key from the captured header
// S_SEARCH | compares entry idx_q per cycle, finishes on hit or last entry
module matcher #(
    parameter int HDR_MAX_LEN = 128,
    parameter int NUM_HEADERS = 16,
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_LEN     = 16,
    parameter int MAX_VAL_LEN = 16
) (
    input logic      clk,
    input logic      rst,
    matcher_if.slave bus
);
    localparam int AW = $clog2(NUM_ENTRIES);
    localparam int HW = $clog2(HDR_MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXTRACT = 2'd1,
        S_SEARCH  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [3:0]                   key_hdr_q, key_hdr_d;
    logic [5:0]                   key_off_q, key_off_d;
    logic [4:0]                   key_len_q, key_len_d;
    logic [KEY_LEN-1:0][7:0]      key_q, key_d;
    logic [AW-1:0]                idx_q, idx_d;

    logic                         ready_q, ready_d;
    logic                         is_match_q, is_match_d;
    logic [MAX_VAL_LEN-1:0][7:0]  args_q, args_d;
    logic [HDR_MAX_LEN-1:0][7:0]  pkt_hdr_q, pkt_hdr_d;
    logic [NUM_HEADERS-1:0][31:0] parsed_hdrs_q, parsed_hdrs_d;

    logic [NUM_ENTRIES-1:0]       tbl_valid_q;
    logic [KEY_LEN-1:0][7:0]      tbl_key_q [NUM_ENTRIES];
    logic [MAX_VAL_LEN-1:0][7:0]  tbl_val_q [NUM_ENTRIES];

    logic [31:0]                  base;
    logic [31:0]                  byte_addr [KEY_LEN];
    logic [KEY_LEN-1:0][7:0]      key_ext;
    logic                         entry_hit;
    logic                         last_entry;

    // Key extraction: bytes past the key length or past the end of the
    // header read as zero so stale bytes never take part in a compare.
    always_comb begin
        base = parsed_hdrs_q[key_hdr_q] + {26'd0, key_off_q};
        for (int i = 0; i < KEY_LEN; i++) begin
            byte_addr[i] = base + 32'(i);
            key_ext[i]   = 8'd0;
            if ((32'(i) < {27'd0, key_len_q}) && (byte_addr[i] < 32'(HDR_MAX_LEN))) begin
                key_ext[i] = pkt_hdr_q[byte_addr[i][HW-1:0]];
            end
        end
    end

    // Only the first key_len bytes are compared; the table's bytes beyond
    // that are don't-care.
    always_comb begin
        entry_hit = tbl_valid_q[idx_q];
        for (int i = 0; i < KEY_LEN; i++) begin
            if ((32'(i) < {27'd0, key_len_q}) && (tbl_key_q[idx_q][i] != key_q[i])) begin
                entry_hit = 1'b0;
            end
        end
    end

    assign last_entry = (idx_q == AW'(NUM_ENTRIES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // A config load wins and swallows a coincident start.
                if (!bus.mod_start_i && bus.start_i) begin
                    state_d = S_EXTRACT;
                end
            end
            S_EXTRACT: state_d = S_SEARCH;
            S_SEARCH: begin
                if (entry_hit || last_entry) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        key_hdr_d     = key_hdr_q;
        key_off_d     = key_off_q;
        key_len_d     = key_len_q;
        key_d         = key_q;
        idx_d         = idx_q;
        ready_d       = 1'b0;
        is_match_d    = is_match_q;
        args_d        = args_q;
        pkt_hdr_d     = pkt_hdr_q;
        parsed_hdrs_d = parsed_hdrs_q;
        case (state_q)
            S_IDLE: begin
                if (bus.mod_start_i) begin
                    key_hdr_d = bus.mod_key_hdr_i;
                    key_off_d = bus.mod_key_off_i;
                    key_len_d = (bus.mod_key_len_i > 5'(KEY_LEN)) ? 5'(KEY_LEN)
                                                                  : bus.mod_key_len_i;
                end else if (bus.start_i) begin
                    pkt_hdr_d     = bus.pkt_hdr_i;
                    parsed_hdrs_d = bus.parsed_hdrs_i;
                end
            end
            S_EXTRACT: begin
                key_d = key_ext;
                idx_d = '0;
            end
            S_SEARCH: begin
                if (entry_hit) begin
                    ready_d    = 1'b1;
                    is_match_d = 1'b1;
                    args_d     = tbl_val_q[idx_q];
                end else if (last_entry) begin
                    ready_d    = 1'b1;
                    is_match_d = 1'b0;
                    args_d     = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

    // Table writes land at the clock edge, so a compare in the same cycle
    // still sees the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_hdr_q     <= '0;
            key_off_q     <= '0;
            key_len_q     <= '0;
            key_q         <= '0;
            idx_q         <= '0;
            ready_q       <= 1'b0;
            is_match_q    <= 1'b0;
            args_q        <= '0;
            pkt_hdr_q     <= '0;
            parsed_hdrs_q <= '0;
            tbl_valid_q   <= '0;
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                tbl_key_q[e] <= '0;
                tbl_val_q[e] <= '0;
            end
        end else begin
            key_hdr_q     <= key_hdr_d;
            key_off_q     <= key_off_d;
            key_len_q     <= key_len_d;
            key_q         <= key_d;
            idx_q         <= idx_d;
            ready_q       <= ready_d;
            is_match_q    <= is_match_d;
            args_q        <= args_d;
            pkt_hdr_q     <= pkt_hdr_d;
            parsed_hdrs_q <= parsed_hdrs_d;
            if (bus.tbl_wr_en_i) begin
                tbl_valid_q[bus.tbl_wr_addr_i] <= bus.tbl_wr_valid_i;
                tbl_key_q[bus.tbl_wr_addr_i]   <= bus.tbl_wr_key_i;
                tbl_val_q[bus.tbl_wr_addr_i]   <= bus.tbl_wr_val_i;
            end
        end
    end

    assign bus.ready_o       = ready_q;
    assign bus.is_match_o    = is_match_q;
    assign bus.args_o        = args_q;
    assign bus.pkt_hdr_o     = pkt_hdr_q;
    assign bus.parsed_hdrs_o = parsed_hdrs_q;
endmodule

// File: tb/tb_matcher.sv
// tb_matcher: directed bench for matcher. Expected values are hand-computed
// from the header pattern hdr[i] = (3*i + 1) mod 256 with bytes 26/27
// overridden to 0x08/0x00, and parsed offsets ph[i] = 4*i except
// ph[2] = 14 and ph[3] = 120.
module tb_matcher;
    localparam int HDR_MAX_LEN = 128;
    localparam int NUM_HEADERS = 16;
    localparam int NUM_ENTRIES = 16;
    localparam int KEY_LEN     = 16;
    localparam int MAX_VAL_LEN = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matcher_if #(
        .HDR_MAX_LEN(HDR_MAX_LEN), .NUM_HEADERS(NUM_HEADERS), .NUM_ENTRIES(NUM_ENTRIES),
        .KEY_LEN(KEY_LEN), .MAX_VAL_LEN(MAX_VAL_LEN)
    ) bus ();

    matcher #(
        .HDR_MAX_LEN(HDR_MAX_LEN), .NUM_HEADERS(NUM_HEADERS), .NUM_ENTRIES(NUM_ENTRIES),
        .KEY_LEN(KEY_LEN), .MAX_VAL_LEN(MAX_VAL_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ready_cnt = 0;

    logic [HDR_MAX_LEN-1:0][7:0]  hdr;
    logic [NUM_HEADERS-1:0][31:0] ph;

    always @(negedge clk) if (bus.ready_o === 1'b1) ready_cnt++;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] h, input logic [5:0] off, input logic [4:0] len);
        bus.mod_start_i   = 1'b1;
        bus.mod_key_hdr_i = h;
        bus.mod_key_off_i = off;
        bus.mod_key_len_i = len;
        step();
        bus.mod_start_i   = 1'b0;
    endtask

    // key bytes: k[7:0] is key byte 0; value bytes v0 (byte 0), v1 (byte 1)
    task automatic set_wr(input logic [3:0] a, input logic v, input logic [31:0] k,
                          input logic [7:0] v0, input logic [7:0] v1);
        bus.tbl_wr_en_i    = 1'b1;
        bus.tbl_wr_addr_i  = a;
        bus.tbl_wr_valid_i = v;
        bus.tbl_wr_key_i   = 128'(k);
        bus.tbl_wr_val_i   = 128'({v1, v0});
    endtask

    task automatic wr(input logic [3:0] a, input logic v, input logic [31:0] k,
                      input logic [7:0] v0, input logic [7:0] v1);
        set_wr(a, v, k, v0, v1);
        step();
        bus.tbl_wr_en_i = 1'b0;
    endtask

    // Issues a start sampled at edge 0 and returns the edge number after
    // which ready_o was seen (-1 if never). ev_kind 1 pulses start_i so it
    // is sampled at edge ev_at; ev_kind 2 writes entry 4 at edge ev_at.
    task automatic lookup(input int ev_at, input int ev_kind, output int lat);
        lat = -1;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n == ev_at) begin
                if (ev_kind == 1) bus.start_i = 1'b1;
                else set_wr(4'd4, 1'b1, 32'h0000_0008, 8'h44, 8'h00);
            end
            step();
            bus.start_i     = 1'b0;
            bus.tbl_wr_en_i = 1'b0;
            if (bus.ready_o === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int cnt0;
        for (int i = 0; i < HDR_MAX_LEN; i++) hdr[i] = 8'((3 * i) + 1);
        hdr[26] = 8'h08;
        hdr[27] = 8'h00;
        for (int i = 0; i < NUM_HEADERS; i++) ph[i] = 32'(4 * i);
        ph[2] = 32'd14;
        ph[3] = 32'd120;

        bus.start_i        = 1'b0;
        bus.pkt_hdr_i      = hdr;
        bus.parsed_hdrs_i  = ph;
        bus.mod_start_i    = 1'b0;
        bus.mod_key_hdr_i  = '0;
        bus.mod_key_off_i  = '0;
        bus.mod_key_len_i  = '0;
        bus.tbl_wr_en_i    = 1'b0;
        bus.tbl_wr_addr_i  = '0;
        bus.tbl_wr_valid_i = 1'b0;
        bus.tbl_wr_key_i   = '0;
        bus.tbl_wr_val_i   = '0;

        // reset values
        #12;
        chk("rst_ready", 1024'(bus.ready_o), 1024'(0));
        chk("rst_match", 1024'(bus.is_match_o), 1024'(0));
        chk("rst_args", 1024'(bus.args_o), 1024'(0));
        chk("rst_pkt_hdr", 1024'(bus.pkt_hdr_o), 1024'(0));
        chk("rst_parsed", 1024'(bus.parsed_hdrs_o), 1024'(0));
        step();
        rst = 1'b0;
        step();

        // hit at entry 0: key = hdr[26..27] = 08 00
        cfg(4'd2, 6'd12, 5'd2);
        wr(4'd0, 1'b1, 32'h0000_0008, 8'hAA, 8'hBB);
        cnt0 = ready_cnt;
        lookup(0, 0, lat);
        chk("hit0_lat", 1024'(lat), 1024'(2));
        chk("hit0_match", 1024'(bus.is_match_o), 1024'(1));
        chk("hit0_args", 1024'(bus.args_o), 1024'(128'hBBAA));
        chk("hit0_pkt_hdr", 1024'(bus.pkt_hdr_o), 1024'(hdr));
        chk("hit0_parsed", 1024'(bus.parsed_hdrs_o), 1024'(ph));
        step();
        chk("hit0_ready_drop", 1024'(bus.ready_o), 1024'(0));
        chk("hit0_args_hold", 1024'(bus.args_o), 1024'(128'hBBAA));
        chk("hit0_one_pulse", 1024'(ready_cnt - cnt0), 1024'(1));

        // priority: 5 and 9 both match, 5 wins after edge 7
        wr(4'd0, 1'b0, 32'h0000_0008, 8'hAA, 8'hBB);
        wr(4'd5, 1'b1, 32'h0000_0008, 8'h55, 8'h00);
        wr(4'd9, 1'b1, 32'h0000_0008, 8'h99, 8'h00);
        lookup(0, 0, lat);
        chk("prio_lat", 1024'(lat), 1024'(7));
        chk("prio_match", 1024'(bus.is_match_o), 1024'(1));
        chk("prio_args", 1024'(bus.args_o), 1024'(128'h55));

        // miss: entry 3 matches but is invalid, entry 1 key 08 01 differs
        wr(4'd5, 1'b0, 32'h0000_0008, 8'h55, 8'h00);
        wr(4'd9, 1'b0, 32'h0000_0008, 8'h99, 8'h00);
        wr(4'd3, 1'b0, 32'h0000_0008, 8'h33, 8'h00);
        wr(4'd1, 1'b1, 32'h0000_0108, 8'h11, 8'h00);
        lookup(0, 0, lat);
        chk("miss_lat", 1024'(lat), 1024'(17));
        chk("miss_match", 1024'(bus.is_match_o), 1024'(0));
        chk("miss_args", 1024'(bus.args_o), 1024'(0));

        // start during SEARCH is ignored
        step();
        cnt0 = ready_cnt;
        lookup(5, 1, lat);
        chk("busy_lat", 1024'(lat), 1024'(17));
        repeat (20) step();
        chk("busy_one_ready", 1024'(ready_cnt - cnt0), 1024'(1));

        // write making entry 4 match at edge 3 -> hit after edge 6
        lookup(3, 2, lat);
        chk("wr3_lat", 1024'(lat), 1024'(6));
        chk("wr3_match", 1024'(bus.is_match_o), 1024'(1));
        chk("wr3_args", 1024'(bus.args_o), 1024'(128'h44));
        step();

        // mod_start with start in IDLE: config loads (len 0), no lookup
        cnt0 = ready_cnt;
        bus.start_i = 1'b1;
        cfg(4'd2, 6'd12, 5'd0);
        bus.start_i = 1'b0;
        repeat (20) step();
        chk("cfg_no_lookup", 1024'(ready_cnt - cnt0), 1024'(0));
        lookup(0, 0, lat);
        chk("len0_lat", 1024'(lat), 1024'(3));
        chk("len0_args", 1024'(bus.args_o), 1024'(128'h11));

        // base 126: bytes 7B 7E then two out-of-range zero bytes
        cfg(4'd3, 6'd6, 5'd4);
        wr(4'd2, 1'b1, 32'h0000_7E7B, 8'h22, 8'h00);
        lookup(0, 0, lat);
        chk("edge_lat", 1024'(lat), 1024'(4));
        chk("edge_args", 1024'(bus.args_o), 1024'(128'h22));

        // base 183: whole key out of range -> zero key entry 6 hits
        cfg(4'd3, 6'd63, 5'd4);
        wr(4'd6, 1'b1, 32'h0000_0000, 8'h66, 8'h00);
        lookup(0, 0, lat);
        chk("oor_lat", 1024'(lat), 1024'(8));
        chk("oor_match", 1024'(bus.is_match_o), 1024'(1));
        chk("oor_args", 1024'(bus.args_o), 1024'(128'h66));
        step();

        // async reset in the middle of SEARCH
        cnt0 = ready_cnt;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 1024'(bus.ready_o), 1024'(0));
        chk("mid_rst_match", 1024'(bus.is_match_o), 1024'(0));
        chk("mid_rst_args", 1024'(bus.args_o), 1024'(0));
        chk("mid_rst_pkt_hdr", 1024'(bus.pkt_hdr_o), 1024'(0));
        chk("mid_rst_parsed", 1024'(bus.parsed_hdrs_o), 1024'(0));
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();
        chk("mid_rst_no_ready", 1024'(ready_cnt - cnt0), 1024'(0));
        lookup(0, 0, lat);
        chk("post_rst_lat", 1024'(lat), 1024'(17));
        chk("post_rst_match", 1024'(bus.is_match_o), 1024'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
